// File: rtl/shift_add_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_pkg
//   Shared FP16 constants and the state type for the iterative significand
//   multiplier. No ports; imported by shift_add_multiplier and its FSM.
// ----------------------------------------------------------------------------
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

package shift_add_multiplier_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_BUSY,
      MUL_DONE
   } mulState_t;

endpackage : shift_add_multiplier_pkg

// File: rtl/shift_add_multiplier_fsm.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_fsm
//   Control for the radix-2 shift/add multiplier. Owns the state and the
//   iteration counter; the parent owns all datapath registers.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   i_start        - level request from the initiator
//   o_load         - accept this edge: latch operands, clear accumulator
//   o_step         - one multiplier bit is consumed this edge
//   o_last         - this step is the final one; the product is written
//   o_done         - registered completion flag (state == DONE)
//   o_count        - current bit index, used as the addend shift amount
// ----------------------------------------------------------------------------
module shift_add_multiplier_fsm
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = `FP16_FRACW + 1,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            i_start,
   output logic            o_load,
   output logic            o_step,
   output logic            o_last,
   output logic            o_done,
   output logic [CNTW-1:0] o_count
);

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

   mulState_t       r_state;
   mulState_t       w_state_next;
   logic [CNTW-1:0] r_count;
   logic [CNTW-1:0] w_count_next;

   // State register.
   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge values; blocking assignments here would create order-dependent
   // races between processes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= MUL_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
      end
   end

   // Next-state logic.
   // NOTE: defaults assigned first so no path leaves a variable unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      unique case (r_state)
         MUL_IDLE: begin
            if (i_start) begin
               w_state_next = MUL_BUSY;
               w_count_next = '0;
            end
         end
         MUL_BUSY: begin
            w_count_next = r_count + CNTW'(1);
            if (r_count == LAST_CNT) w_state_next = MUL_DONE;
         end
         MUL_DONE: begin
            // A held start never retriggers; the initiator must drop it.
            if (!i_start) w_state_next = MUL_IDLE;
         end
         default: w_state_next = MUL_IDLE;
      endcase
   end

   // Outputs. done comes from registered state only, never from start.
   always_comb begin
      o_load  = (r_state == MUL_IDLE) && i_start;
      o_step  = (r_state == MUL_BUSY);
      o_last  = (r_state == MUL_BUSY) && (r_count == LAST_CNT);
      o_done  = (r_state == MUL_DONE);
      o_count = r_count;
   end

endmodule : shift_add_multiplier_fsm

// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
//   Iterative radix-2 unsigned multiplier for FP16 significands (hidden bit
//   included). Samples operands on an accepted start, consumes one multiplier
//   bit per cycle and holds a level done with a stable product.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   mulIn1         - multiplicand, sampled only on accept
//   mulIn2         - multiplier, sampled only on accept
//   start          - level request; may stay high indefinitely
//   mulOut         - product, held until the next completion
//   done           - level completion flag
// OUTWIDTH must equal 2*WIDTH; the accumulator then cannot overflow.
// ----------------------------------------------------------------------------
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH    = `FP16_FRACW + 1,
   parameter int OUTWIDTH = 2 * WIDTH,
   parameter int CNTW     = $clog2(WIDTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [WIDTH-1:0]    mulIn1,
   input  logic [WIDTH-1:0]    mulIn2,
   input  logic                start,
   output logic [OUTWIDTH-1:0] mulOut,
   output logic                done
);

   logic                w_load;
   logic                w_step;
   logic                w_last;
   logic                w_done;
   logic [CNTW-1:0]     w_count;

   logic [WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [OUTWIDTH-1:0] r_acc;
   logic [OUTWIDTH-1:0] r_mulOut;

   logic [OUTWIDTH-1:0] w_addend;
   logic [OUTWIDTH-1:0] w_acc_next;

   shift_add_multiplier_fsm #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
   ) u_fsm (
      .clock   (clock),
      .reset   (reset),
      .i_start (start),
      .o_load  (w_load),
      .o_step  (w_step),
      .o_last  (w_last),
      .o_done  (w_done),
      .o_count (w_count)
   );

   // The multiplicand is widened before shifting so high partial-product
   // bits are never lost.
   assign w_addend   = {{(OUTWIDTH - WIDTH){1'b0}}, r_mcand} << w_count;
   assign w_acc_next = r_mplier[0] ? (r_acc + w_addend) : r_acc;

   // NOTE: every datapath register, including the held product, is cleared
   // by reset so no partial or stale result survives an abort.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_mulOut <= '0;
      end else if (w_load) begin
         r_mcand  <= mulIn1;
         r_mplier <= mulIn2;
         r_acc    <= '0;
      end else if (w_step) begin
         r_acc    <= w_acc_next;
         r_mplier <= r_mplier >> 1;
         // The final add lands directly in the product register.
         if (w_last) r_mulOut <= w_acc_next;
      end
   end

   assign mulOut = r_mulOut;
   assign done   = w_done;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Self-checking bench for shift_add_multiplier. Expected products come from
//   plain integer multiplication; the expected latency is the operand width.
// ----------------------------------------------------------------------------
module tb_shift_add_multiplier;

   localparam int W  = 11;
   localparam int OW = 22;
   localparam int LAT = W;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  mul_in1;
   logic [W-1:0]  mul_in2;
   logic          start;
   logic [OW-1:0] mul_out;
   logic          done_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_add_multiplier dut (
      .clock  (clk),
      .reset  (rst),
      .mulIn1 (mul_in1),
      .mulIn2 (mul_in2),
      .start  (start),
      .mulOut (mul_out),
      .done   (done_o)
   );

   function automatic logic [OW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned p;
      p = int'(a) * int'(b);
      return OW'(p);
   endfunction

   // Raise start with operands, wait for the accept edge, then count edges
   // until done is seen. lat = -1 if the bound expires. When disturb is set,
   // the inputs are changed and start toggled while the operation runs.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, output int lat);
      @(negedge clk);
      mul_in1 = a;
      mul_in2 = b;
      start   = 1'b1;
      @(posedge clk);
      lat = -1;
      if (disturb) begin
         #1;
         mul_in1 = 11'h7FF;
         mul_in2 = 11'h7FF;
      end
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done_o) begin
            lat = n;
            break;
         end
         if (disturb) start = ~start;
      end
      start = 1'b1;
   endtask

   task automatic drop_start();
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      mul_in1 = '0;
      mul_in2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || mul_out !== '0) begin
         bad++;
         $display("FAIL reset_state: done=%b mulOut=%h required done=0 mulOut=0", done_o, mul_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      logic [OW-1:0] held;
      run_op(11'h400, 11'h400, 1'b0, lat);
      total++;
      if (lat != LAT) begin
         bad++;
         $display("FAIL basic_latency: got %0d required %0d", lat, LAT);
      end
      total++;
      if (mul_out !== 22'h100000) begin
         bad++;
         $display("FAIL basic_product: got %h required %h", mul_out, 22'h100000);
      end
      held = mul_out;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (done_o !== 1'b1 || mul_out !== 22'h100000) begin
         bad++;
         $display("FAIL done_hold: done=%b mulOut=%h required done=1 mulOut=%h", done_o, mul_out, held);
      end
      drop_start();
   endtask

   task automatic test_max_zero();
      int lat;
      run_op(11'h7FF, 11'h7FF, 1'b0, lat);
      total++;
      if (lat != LAT || mul_out !== 22'h3FF001) begin
         bad++;
         $display("FAIL max_operands: lat=%0d mulOut=%h required lat=%0d mulOut=%h", lat, mul_out, LAT, 22'h3FF001);
      end
      drop_start();
      run_op(11'h000, 11'h5A5, 1'b0, lat);
      total++;
      if (lat != LAT || mul_out !== 22'h0) begin
         bad++;
         $display("FAIL zero_operand: lat=%0d mulOut=%h required lat=%0d mulOut=0", lat, mul_out, LAT);
      end
      drop_start();
   endtask

   task automatic test_input_change();
      int lat;
      run_op(11'h003, 11'h005, 1'b1, lat);
      total++;
      if (lat != LAT || mul_out !== 22'h00000F) begin
         bad++;
         $display("FAIL input_change: lat=%0d mulOut=%h required lat=%0d mulOut=%h", lat, mul_out, LAT, 22'h00000F);
      end
      drop_start();
   endtask

   task automatic test_async_reset();
      int lat;
      // Leave a nonzero product visible so the reset clear is observable.
      run_op(11'h123, 11'h045, 1'b0, lat);
      total++;
      if (mul_out !== ref_mul(11'h123, 11'h045)) begin
         bad++;
         $display("FAIL pre_reset_product: got %h required %h", mul_out, ref_mul(11'h123, 11'h045));
      end
      drop_start();
      @(negedge clk);
      mul_in1 = 11'h7FF;
      mul_in2 = 11'h7FF;
      start   = 1'b1;
      @(posedge clk);            // accept edge
      repeat (4) @(posedge clk); // now in the 5th BUSY cycle
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (done_o !== 1'b0 || mul_out !== '0) begin
         bad++;
         $display("FAIL async_reset: done=%b mulOut=%h required done=0 mulOut=0", done_o, mul_out);
      end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_op(11'h002, 11'h003, 1'b0, lat);
      total++;
      if (lat != LAT || mul_out !== 22'd6) begin
         bad++;
         $display("FAIL after_reset: lat=%0d mulOut=%h required lat=%0d mulOut=6", lat, mul_out, LAT);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [OW-1:0] prev;
      // Previous test ended in DONE with start high.
      prev = ref_mul(11'h002, 11'h003);
      drop_start();
      total++;
      if (done_o !== 1'b0 || mul_out !== prev) begin
         bad++;
         $display("FAIL done_fall: done=%b mulOut=%h required done=0 mulOut=%h", done_o, mul_out, prev);
      end
      @(negedge clk);
      mul_in1 = 11'h401;
      mul_in2 = 11'h002;
      start   = 1'b1;
      @(posedge clk);
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (done_o !== 1'b0 || mul_out !== prev) begin
         bad++;
         $display("FAIL prev_held: done=%b mulOut=%h required done=0 mulOut=%h", done_o, mul_out, prev);
      end
      lat = -1;
      for (int n = 7; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done_o) begin
            lat = n;
            break;
         end
      end
      total++;
      if (lat != LAT || mul_out !== 22'h000802) begin
         bad++;
         $display("FAIL back_to_back: lat=%0d mulOut=%h required lat=%0d mulOut=%h", lat, mul_out, LAT, 22'h000802);
      end
      drop_start();
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [OW-1:0] exp_p;
      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom_range(0, (1 << W) - 1));
         b = W'($urandom_range(0, (1 << W) - 1));
         exp_p = ref_mul(a, b);
         run_op(a, b, 1'b0, lat);
         total++;
         if (lat != LAT || mul_out !== exp_p) begin
            bad++;
            $display("FAIL random[%0d]: %h*%h lat=%0d mulOut=%h required lat=%0d mulOut=%h",
                     i, a, b, lat, mul_out, LAT, exp_p);
         end
         drop_start();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_zero();
      test_input_change();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_add_multiplier
